// File: rtl/riscv_pkg.sv
// Shared core definitions: canonical NOP encoding and the instruction-fetch FSM states.
package riscv_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory req/gnt/rvalid bus between the fetch stage (master) and memory (slave).
interface fetch_stage_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, single-outstanding imem request FSM,
// stall hold buffer and branch/jump redirect handling.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = riscv_pkg::NOP_INST
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          stall_f,
  input  logic          redirect_f,
  input  logic [31:0]   redirect_pc,
  fetch_stage_if.master imem,
  output logic [31:0]   pc_f,
  output logic [31:0]   pc_plus_4_f,
  output logic [31:0]   inst_f,
  output logic          inst_valid_f
);

  import riscv_pkg::*;

  fetch_state_e state_r, state_s;
  logic [31:0]  pc_r, pc_s;
  logic [31:0]  buf_r, buf_s;
  logic [31:0]  pc_plus_4_s;
  logic [31:0]  target_s;
  logic         req_s;
  logic [31:0]  addr_s;
  logic         valid_s;
  logic [31:0]  inst_s;

  assign pc_plus_4_s = pc_r + 32'd4;
  assign target_s    = redirect_pc & ~32'd3;

  // State, PC and hold-buffer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      pc_r    <= RESET_PC;
      buf_r   <= NOP_INST;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      buf_r   <= buf_s;
    end
  end

  // Next-state, next-PC and request/instruction outputs.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    buf_s   = buf_r;
    req_s   = 1'b0;
    addr_s  = pc_r;
    valid_s = 1'b0;
    inst_s  = NOP_INST;
    case (state_r)
      IDLE: begin
        if (redirect_f) begin
          pc_s = target_s;
        end else begin
          req_s = 1'b1;
          if (imem.imem_gnt) state_s = WAIT;
          else               state_s = IDLE;
        end
      end
      WAIT: begin
        if (imem.imem_rvalid) begin
          if (redirect_f) begin
            pc_s    = target_s;
            state_s = IDLE;
          end else begin
            valid_s = 1'b1;
            inst_s  = imem.imem_rdata;
            if (stall_f) begin
              buf_s   = imem.imem_rdata;
              state_s = HOLD;
            end else begin
              // Consume: chain the next fetch in the same cycle.
              pc_s    = pc_plus_4_s;
              req_s   = 1'b1;
              addr_s  = pc_plus_4_s;
              state_s = imem.imem_gnt ? WAIT : IDLE;
            end
          end
        end else if (redirect_f) begin
          pc_s    = target_s;
          state_s = DROP;
        end else begin
          state_s = WAIT;
        end
      end
      HOLD: begin
        if (redirect_f) begin
          pc_s    = target_s;
          state_s = IDLE;
        end else begin
          valid_s = 1'b1;
          inst_s  = buf_r;
          if (stall_f) begin
            state_s = HOLD;
          end else begin
            pc_s    = pc_plus_4_s;
            req_s   = 1'b1;
            addr_s  = pc_plus_4_s;
            state_s = imem.imem_gnt ? WAIT : IDLE;
          end
        end
      end
      DROP: begin
        if (redirect_f) pc_s = target_s;
        else            pc_s = pc_r;
        // The stale response retires the outstanding request.
        if (imem.imem_rvalid) state_s = IDLE;
        else                  state_s = DROP;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // IDLE requests combinationally, so mask the request while reset is held.
  assign imem.imem_req  = req_s & reset_n;
  assign imem.imem_addr = addr_s;
  assign pc_f           = pc_r;
  assign pc_plus_4_f    = pc_plus_4_s;
  assign inst_f         = inst_s;
  assign inst_valid_f   = valid_s;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage against a latency-configurable instruction-memory responder.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall_f = 1'b0;
  logic        redirect_f = 1'b0;
  logic [31:0] redirect_pc = 32'h0000_0000;
  logic [31:0] pc_f, pc_plus_4_f, inst_f;
  logic        inst_valid_f;

  int checks = 0;
  int errors = 0;

  logic        gnt_en = 1'b1;
  int          lat = 1;
  logic        pend;
  int          cnt;
  logic [31:0] paddr;
  logic        rvalid_s;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .stall_f      (stall_f),
    .redirect_f   (redirect_f),
    .redirect_pc  (redirect_pc),
    .imem         (bus.master),
    .pc_f         (pc_f),
    .pc_plus_4_f  (pc_plus_4_f),
    .inst_f       (inst_f),
    .inst_valid_f (inst_valid_f)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  assign rvalid_s        = pend && (cnt == 0);
  assign bus.imem_gnt    = gnt_en;
  assign bus.imem_rvalid = rvalid_s;
  assign bus.imem_rdata  = rvalid_s ? mem_word(paddr) : 32'hBAD0_BAD0;

  // Memory responder: one outstanding read, answered lat cycles after grant.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend  <= 1'b0;
      cnt   <= 0;
      paddr <= 32'h0000_0000;
    end else begin
      if (bus.imem_req && bus.imem_gnt) begin
        pend  <= 1'b1;
        cnt   <= lat - 1;
        paddr <= bus.imem_addr;
      end else if (rvalid_s) begin
        pend <= 1'b0;
      end else if (pend) begin
        cnt <= cnt - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string tag, input logic req, input logic [31:0] addr,
                      input logic valid, input logic [31:0] inst, input logic [31:0] pc);
    chk({tag, ".req"}, {31'd0, bus.imem_req}, {31'd0, req});
    if (req) chk({tag, ".addr"}, bus.imem_addr, addr);
    chk({tag, ".valid"}, {31'd0, inst_valid_f}, {31'd0, valid});
    chk({tag, ".inst"}, inst_f, inst);
    chk({tag, ".pc"}, pc_f, pc);
    chk({tag, ".pc4"}, pc_plus_4_f, pc + 32'd4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] nop;
    nop = 32'h0000_0013;
    #3;
    outs("reset", 1'b0, 32'h0, 1'b0, nop, 32'h0000_0000);

    // Release reset; zero-wait streaming from 0x0.
    step(); reset_n = 1'b1;
    @(negedge clk); outs("c0", 1'b1, 32'h0000_0000, 1'b0, nop, 32'h0000_0000);
    step(); @(negedge clk); outs("c1", 1'b1, 32'h0000_0004, 1'b1, 32'hDEAD_0000, 32'h0000_0000);
    step(); @(negedge clk); outs("c2", 1'b1, 32'h0000_0008, 1'b1, 32'hDEAD_0004, 32'h0000_0004);

    // Stall three cycles at 0x8.
    step(); stall_f = 1'b1;
    @(negedge clk); outs("stall0", 1'b0, 32'h0, 1'b1, 32'hDEAD_0008, 32'h0000_0008);
    step(); @(negedge clk); outs("stall1", 1'b0, 32'h0, 1'b1, 32'hDEAD_0008, 32'h0000_0008);
    step(); @(negedge clk); outs("stall2", 1'b0, 32'h0, 1'b1, 32'hDEAD_0008, 32'h0000_0008);
    step(); stall_f = 1'b0;
    @(negedge clk); outs("unstall", 1'b1, 32'h0000_000C, 1'b1, 32'hDEAD_0008, 32'h0000_0008);

    // Slow response for 0x10, redirected to 0x100 while pending.
    step(); lat = 4;
    @(negedge clk); outs("c7", 1'b1, 32'h0000_0010, 1'b1, 32'hDEAD_000C, 32'h0000_000C);
    step(); @(negedge clk); outs("wait10", 1'b0, 32'h0, 1'b0, nop, 32'h0000_0010);
    step(); redirect_f = 1'b1; redirect_pc = 32'h0000_0100;
    @(negedge clk); outs("redir", 1'b0, 32'h0, 1'b0, nop, 32'h0000_0010);
    step(); redirect_f = 1'b0; lat = 1;
    @(negedge clk); outs("drop0", 1'b0, 32'h0, 1'b0, nop, 32'h0000_0100);
    step(); @(negedge clk); outs("drop_stale", 1'b0, 32'h0, 1'b0, nop, 32'h0000_0100);
    chk("stale_rvalid", {31'd0, bus.imem_rvalid}, 32'd1);
    step(); @(negedge clk); outs("tgt_req", 1'b1, 32'h0000_0100, 1'b0, nop, 32'h0000_0100);
    step(); @(negedge clk); outs("tgt_inst", 1'b1, 32'h0000_0104, 1'b1, 32'hDEAD_0100, 32'h0000_0100);

    // Redirect (unaligned target) and stall together: redirect wins.
    step(); redirect_f = 1'b1; stall_f = 1'b1; redirect_pc = 32'h0000_0203;
    @(negedge clk); outs("rs", 1'b0, 32'h0, 1'b0, nop, 32'h0000_0104);
    step(); redirect_f = 1'b0; stall_f = 1'b0;
    @(negedge clk); outs("rs_req", 1'b1, 32'h0000_0200, 1'b0, nop, 32'h0000_0200);

    // Redirect from IDLE to the top word: request withdrawn, then PC wraps.
    #1; redirect_f = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    #1; chk("idle_redir.req", {31'd0, bus.imem_req}, 32'd0);
    step(); redirect_f = 1'b0;
    @(negedge clk); outs("top", 1'b1, 32'hFFFF_FFFC, 1'b0, nop, 32'hFFFF_FFFC);
    chk("wrap.pc4", pc_plus_4_f, 32'h0000_0000);
    step(); @(negedge clk); outs("top_inst", 1'b1, 32'h0000_0000, 1'b1, 32'h2152_FFFC, 32'hFFFF_FFFC);

    // Grant back-pressure: request for 0x4 must hold steady.
    step(); gnt_en = 1'b0;
    @(negedge clk); outs("bp_issue", 1'b1, 32'h0000_0004, 1'b1, 32'hDEAD_0000, 32'h0000_0000);
    for (int i = 0; i < 4; i++) begin
      step(); @(negedge clk); outs("bp_hold", 1'b1, 32'h0000_0004, 1'b0, nop, 32'h0000_0004);
    end
    step(); gnt_en = 1'b1; lat = 3;
    @(negedge clk); outs("bp_gnt", 1'b1, 32'h0000_0004, 1'b0, nop, 32'h0000_0004);
    step(); @(negedge clk); outs("bp_wait", 1'b0, 32'h0, 1'b0, nop, 32'h0000_0004);

    // Asynchronous reset in WAIT.
    #2; reset_n = 1'b0;
    #1; outs("async_rst", 1'b0, 32'h0, 1'b0, nop, 32'h0000_0000);
    step(); reset_n = 1'b1; lat = 1;
    @(negedge clk); outs("rst2_req", 1'b1, 32'h0000_0000, 1'b0, nop, 32'h0000_0000);
    step(); @(negedge clk); outs("rst2_inst", 1'b1, 32'h0000_0004, 1'b1, 32'hDEAD_0000, 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
